// File: rtl/fix_tx_session_arbiter.sv
// Frame-atomic two-class round-robin arbiter that merges N_SESS FIX encoder
// sessions onto one 64-bit stream toward the Ethernet TX wrapper.
module fix_tx_session_arbiter #(
  parameter int N_SESS = 4,
  parameter int SID_W  = 2
) (
  input  logic                  clk156,
  input  logic                  rstn,
  input  logic [64*N_SESS-1:0]  s_data,
  input  logic [N_SESS-1:0]     s_valid,
  input  logic [N_SESS-1:0]     s_last,
  output logic [N_SESS-1:0]     s_ready,
  input  logic [N_SESS-1:0]     sess_enable,
  input  logic [N_SESS-1:0]     sess_prio,
  output logic [63:0]           m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [SID_W-1:0]      grant_id,
  output logic                  busy,
  output logic [31:0]           frame_count,
  output logic [31:0]           hp_win_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [SID_W-1:0]  grant_r, grant_nxt_s;
  logic [SID_W-1:0]  rr_hi_r, rr_hi_nxt_s;
  logic [SID_W-1:0]  rr_lo_r, rr_lo_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              m_valid_r, m_valid_nxt_s;
  logic              m_last_r, m_last_nxt_s;
  logic [63:0]       m_data_r, m_data_nxt_s;
  logic [31:0]       frame_cnt_r, frame_cnt_nxt_s;
  logic [31:0]       hp_win_r, hp_win_nxt_s;

  logic [N_SESS-1:0] req_s, hp_req_s, lp_req_s, s_ready_s;
  logic [SID_W-1:0]  hp_pick_s, lp_pick_s;
  logic              out_free_s, accept_s, sel_valid_s, sel_last_s;
  logic [63:0]       sel_data_s;

  // First requester at or after ptr, scanning upward with wrap at N_SESS.
  function automatic logic [SID_W-1:0] rr_pick(input logic [N_SESS-1:0] vec,
                                               input logic [SID_W-1:0]  ptr);
    logic found;
    int   j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < N_SESS; k++) begin
      j = int'(ptr) + k;
      if (j >= N_SESS) begin
        j = j - N_SESS;
      end else begin
        j = j;
      end
      if (!found && vec[j]) begin
        rr_pick = SID_W'(j);
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  function automatic logic [SID_W-1:0] next_ptr(input logic [SID_W-1:0] winner);
    if (int'(winner) == N_SESS - 1) begin
      next_ptr = {SID_W{1'b0}};
    end else begin
      next_ptr = winner + SID_W'(1'b1);
    end
  endfunction

  assign req_s      = s_valid & sess_enable;
  assign hp_req_s   = req_s & sess_prio;
  assign lp_req_s   = req_s & ~sess_prio;
  assign hp_pick_s  = rr_pick(hp_req_s, rr_hi_r);
  assign lp_pick_s  = rr_pick(lp_req_s, rr_lo_r);
  assign out_free_s = !m_valid_r || m_ready;

  // Granted-session mux; enable is ignored here so a granted frame always completes.
  always_comb begin
    sel_valid_s = s_valid[grant_r];
    sel_last_s  = s_last[grant_r];
    sel_data_s  = s_data[int'(grant_r)*64 +: 64];
  end

  // Only the granted session sees ready, and only while the output register can take a beat.
  always_comb begin
    s_ready_s = {N_SESS{1'b0}};
    if (state_r == ST_XFER) begin
      s_ready_s[grant_r] = out_free_s;
    end else begin
      s_ready_s = {N_SESS{1'b0}};
    end
  end

  assign accept_s = (state_r == ST_XFER) && sel_valid_s && out_free_s;

  // Next-state, arbitration and output-register logic.
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    rr_hi_nxt_s     = rr_hi_r;
    rr_lo_nxt_s     = rr_lo_r;
    busy_nxt_s      = busy_r;
    m_valid_nxt_s   = m_valid_r;
    m_last_nxt_s    = m_last_r;
    m_data_nxt_s    = m_data_r;
    frame_cnt_nxt_s = frame_cnt_r;
    hp_win_nxt_s    = hp_win_r;

    if (accept_s) begin
      m_valid_nxt_s = 1'b1;
      m_data_nxt_s  = sel_data_s;
      m_last_nxt_s  = sel_last_s;
    end else if (m_ready) begin
      m_valid_nxt_s = 1'b0;
    end else begin
      m_valid_nxt_s = m_valid_r;
    end

    if (m_valid_r && m_ready && m_last_r) begin
      frame_cnt_nxt_s = frame_cnt_r + 32'd1;
    end else begin
      frame_cnt_nxt_s = frame_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        // The previous frame's last beat may still be in the output register here.
        if (hp_req_s != {N_SESS{1'b0}}) begin
          grant_nxt_s = hp_pick_s;
          rr_hi_nxt_s = next_ptr(hp_pick_s);
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_XFER;
          if (lp_req_s != {N_SESS{1'b0}}) begin
            hp_win_nxt_s = hp_win_r + 32'd1;
          end else begin
            hp_win_nxt_s = hp_win_r;
          end
        end else if (lp_req_s != {N_SESS{1'b0}}) begin
          grant_nxt_s = lp_pick_s;
          rr_lo_nxt_s = next_ptr(lp_pick_s);
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_XFER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept_s && sel_last_s) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset mid-frame simply drops the frame.
  always_ff @(posedge clk156 or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      grant_r     <= {SID_W{1'b0}};
      rr_hi_r     <= {SID_W{1'b0}};
      rr_lo_r     <= {SID_W{1'b0}};
      busy_r      <= 1'b0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      m_data_r    <= 64'd0;
      frame_cnt_r <= 32'd0;
      hp_win_r    <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      rr_hi_r     <= rr_hi_nxt_s;
      rr_lo_r     <= rr_lo_nxt_s;
      busy_r      <= busy_nxt_s;
      m_valid_r   <= m_valid_nxt_s;
      m_last_r    <= m_last_nxt_s;
      m_data_r    <= m_data_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      hp_win_r    <= hp_win_nxt_s;
    end
  end

  assign s_ready      = s_ready_s;
  assign m_data       = m_data_r;
  assign m_valid      = m_valid_r;
  assign m_last       = m_last_r;
  assign grant_id     = grant_r;
  assign busy         = busy_r;
  assign frame_count  = frame_cnt_r;
  assign hp_win_count = hp_win_r;

endmodule
